// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg -- shared definitions for the decode stage.
//
// Contents:
//   word_t       64-bit signed machine word
//   reg_idx_t    4-bit register specifier (4'hF = no register)
//   I_*          instruction codes HALT (0) .. POPQ (B)
//   RSP, RNONE   stack-pointer index and the "no register" specifier
//   reset_value  per-register reset contents
//
// Configuration macro: DECODE_STACK_INIT_EN
//   defined   -> %rsp (register 4) resets to 64'h100
//   undefined -> every register resets to 0
// -----------------------------------------------------------------------------
package decode_pkg;

    typedef logic signed [63:0] word_t;
    typedef logic [3:0]         reg_idx_t;

    localparam int unsigned NUM_REGS = 15;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam reg_idx_t RSP   = 4'h4;
    localparam reg_idx_t RNONE = 4'hF;

    localparam word_t STACK_INIT = 64'sh0000_0000_0000_0100;

    // Reset contents of register idx.
    function automatic word_t reset_value(input int unsigned idx);
`ifdef DECODE_STACK_INIT_EN
        return (idx == 32'(RSP)) ? STACK_INIT : 64'sh0;
`else
        return (idx == 32'(RSP)) ? 64'sh0 : 64'sh0;
`endif
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// -----------------------------------------------------------------------------
// decode_regfile -- 15 x 64-bit register file, 2 read / 2 write ports.
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   src_a_i, src_b_i      read specifiers (RNONE reads as 0)
//   rd_a_o, rd_b_o        combinational read data (pre-edge contents)
//   dst_e_i, val_e_i      write port E (RNONE writes nothing)
//   dst_m_i, val_m_i      write port M, wins over E on the same index
//   regs_o                all 15 registers, element N = register N
//
// Configuration macro: DECODE_STACK_INIT_EN (reset value of %rsp, see pkg).
// -----------------------------------------------------------------------------
module decode_regfile
    import decode_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  reg_idx_t                     src_a_i,
    input  reg_idx_t                     src_b_i,
    output word_t                        rd_a_o,
    output word_t                        rd_b_o,
    input  reg_idx_t                     dst_e_i,
    input  word_t                        val_e_i,
    input  reg_idx_t                     dst_m_i,
    input  word_t                        val_m_i,
    output logic [NUM_REGS-1:0][63:0]    regs_o
);

    logic [NUM_REGS-1:0][63:0] regs_q;
    logic [NUM_REGS-1:0][63:0] regs_d;

    // Next-state: M port checked first so it overrides E (popq %rsp).
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = (dst_m_i == 4'(i)) ? val_m_i :
                        (dst_e_i == 4'(i)) ? val_e_i : regs_q[i];
        end
    end

    // Register storage; reset clears immediately and blocks writes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= reset_value(i);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: no bypass, so same-cycle writes are not visible.
    always_comb begin
        rd_a_o = (src_a_i == RNONE) ? 64'sh0 : regs_q[src_a_i];
        rd_b_o = (src_b_i == RNONE) ? 64'sh0 : regs_q[src_b_i];
    end

    assign regs_o = regs_q;

endmodule

// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode -- decode stage: selects source/destination registers from icode
// and hosts the register file.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   icode, rA, rB       instruction code and register specifiers (F = none)
//   cnd                 condition flag, gates the cmovXX (icode 2) write
//   valE, valM          execute / memory results written back on clk rise
//   valA, valB          combinational operand reads (0 when source is none)
//   reg_f0 .. reg_f14   live register contents (reg_f4 = %rsp)
//
// Configuration macro: DECODE_STACK_INIT_EN -- %rsp resets to 64'h100.
// -----------------------------------------------------------------------------
module decode
    import decode_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         icode,
    input  logic [3:0]         rA,
    input  logic [3:0]         rB,
    input  logic               cnd,
    input  logic signed [63:0] valM,
    input  logic signed [63:0] valE,
    output logic signed [63:0] valA,
    output logic signed [63:0] valB,
    output logic signed [63:0] reg_f0,
    output logic signed [63:0] reg_f1,
    output logic signed [63:0] reg_f2,
    output logic signed [63:0] reg_f3,
    output logic signed [63:0] reg_f4,
    output logic signed [63:0] reg_f5,
    output logic signed [63:0] reg_f6,
    output logic signed [63:0] reg_f7,
    output logic signed [63:0] reg_f8,
    output logic signed [63:0] reg_f9,
    output logic signed [63:0] reg_f10,
    output logic signed [63:0] reg_f11,
    output logic signed [63:0] reg_f12,
    output logic signed [63:0] reg_f13,
    output logic signed [63:0] reg_f14
);

    reg_idx_t                  src_a;
    reg_idx_t                  src_b;
    reg_idx_t                  dst_e;
    reg_idx_t                  dst_m;
    logic [NUM_REGS-1:0][63:0] regs;

    // Register selection from instruction code.
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            I_RRMOVQ: begin
                src_a = rA;
                dst_e = cnd ? rB : RNONE;
            end
            I_IRMOVQ: begin
                dst_e = rB;
            end
            I_RMMOVQ: begin
                src_a = rA;
                src_b = rB;
            end
            I_MRMOVQ: begin
                src_b = rB;
                dst_m = rA;
            end
            I_OPQ: begin
                src_a = rA;
                src_b = rB;
                dst_e = rB;
            end
            I_CALL: begin
                src_b = RSP;
                dst_e = RSP;
            end
            I_RET: begin
                src_a = RSP;
                src_b = RSP;
                dst_e = RSP;
            end
            I_PUSHQ: begin
                src_a = rA;
                src_b = RSP;
                dst_e = RSP;
            end
            I_POPQ: begin
                src_a = RSP;
                src_b = RSP;
                dst_e = RSP;
                dst_m = rA;
            end
            default: begin
                // HALT, NOP, JXX and undefined codes touch no register.
                src_a = RNONE;
                src_b = RNONE;
                dst_e = RNONE;
                dst_m = RNONE;
            end
        endcase
    end

    decode_regfile u_regfile (
        .clk_i   (clk),
        .reset_i (reset),
        .src_a_i (src_a),
        .src_b_i (src_b),
        .rd_a_o  (valA),
        .rd_b_o  (valB),
        .dst_e_i (dst_e),
        .val_e_i (valE),
        .dst_m_i (dst_m),
        .val_m_i (valM),
        .regs_o  (regs)
    );

    assign reg_f0  = regs[0];
    assign reg_f1  = regs[1];
    assign reg_f2  = regs[2];
    assign reg_f3  = regs[3];
    assign reg_f4  = regs[4];
    assign reg_f5  = regs[5];
    assign reg_f6  = regs[6];
    assign reg_f7  = regs[7];
    assign reg_f8  = regs[8];
    assign reg_f9  = regs[9];
    assign reg_f10 = regs[10];
    assign reg_f11 = regs[11];
    assign reg_f12 = regs[12];
    assign reg_f13 = regs[13];
    assign reg_f14 = regs[14];

endmodule

// File: tb/tb_decode.sv
// -----------------------------------------------------------------------------
// tb_decode -- scoreboard bench for decode.
// The driver applies one instruction per cycle shortly after the rising edge,
// pushes the expected operands and the expected register contents (state
// before that instruction's edge) and then advances the reference model.
// The monitor pops one entry per falling edge and compares.
// -----------------------------------------------------------------------------
module tb_decode;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [3:0]         icode = 4'h0;
    logic [3:0]         rA = 4'hF;
    logic [3:0]         rB = 4'hF;
    logic               cnd = 1'b0;
    logic signed [63:0] valM = 64'sh0;
    logic signed [63:0] valE = 64'sh0;
    logic signed [63:0] valA, valB;
    logic signed [63:0] reg_f0, reg_f1, reg_f2, reg_f3, reg_f4, reg_f5, reg_f6, reg_f7;
    logic signed [63:0] reg_f8, reg_f9, reg_f10, reg_f11, reg_f12, reg_f13, reg_f14;

    decode dut (
        .clk(clk), .reset(reset), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valM(valM), .valE(valE), .valA(valA), .valB(valB),
        .reg_f0(reg_f0), .reg_f1(reg_f1), .reg_f2(reg_f2), .reg_f3(reg_f3),
        .reg_f4(reg_f4), .reg_f5(reg_f5), .reg_f6(reg_f6), .reg_f7(reg_f7),
        .reg_f8(reg_f8), .reg_f9(reg_f9), .reg_f10(reg_f10), .reg_f11(reg_f11),
        .reg_f12(reg_f12), .reg_f13(reg_f13), .reg_f14(reg_f14)
    );

    always #5 clk = ~clk;

    logic [63:0] dut_regs [15];
    always_comb begin
        dut_regs[0]  = reg_f0;  dut_regs[1]  = reg_f1;  dut_regs[2]  = reg_f2;
        dut_regs[3]  = reg_f3;  dut_regs[4]  = reg_f4;  dut_regs[5]  = reg_f5;
        dut_regs[6]  = reg_f6;  dut_regs[7]  = reg_f7;  dut_regs[8]  = reg_f8;
        dut_regs[9]  = reg_f9;  dut_regs[10] = reg_f10; dut_regs[11] = reg_f11;
        dut_regs[12] = reg_f12; dut_regs[13] = reg_f13; dut_regs[14] = reg_f14;
    end

    typedef struct packed {
        logic [63:0]       a;
        logic [63:0]       b;
        logic [14:0][63:0] regs;
    } item_t;

    item_t       sb [$];
    logic [63:0] mdl [15];
    int          n_vec = 0;
    int          n_bad = 0;

    // ---- reference model: register roles straight from the instruction table
    function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB})             return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6})       return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
        if (ic == 4'h2)                         return c ? rb : 4'hF;
        if (ic inside {4'h3, 4'h6})             return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return 4'hF;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] idx);
        return (idx == 4'hF) ? 64'h0 : mdl[idx];
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 15; i++) mdl[i] = 64'h0;
`ifdef DECODE_STACK_INIT_EN
        mdl[4] = 64'h100;
`endif
    endtask

    task automatic push_expect();
        item_t it;
        it.a = m_read(m_src_a(icode, rA));
        it.b = m_read(m_src_b(icode, rB));
        for (int i = 0; i < 15; i++) it.regs[i] = mdl[i];
        sb.push_back(it);
    endtask

    // One instruction per cycle; writes land on the next rising edge.
    task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic c, input logic [63:0] ve, input logic [63:0] vm);
        logic [3:0] de, dm;
        @(posedge clk);
        #2;
        reset = 1'b0;
        icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm;
        push_expect();
        de = m_dst_e(ic, rb, c);
        dm = m_dst_m(ic, ra);
        if (de != 4'hF) mdl[de] = ve;
        if (dm != 4'hF) mdl[dm] = vm;
    endtask

    // Reset raised between edges; the registers must clear before the next edge.
    task automatic reset_pulse();
        @(posedge clk);
        #2;
        reset = 1'b1;
        reset_model();
        push_expect();
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: one scoreboard entry checked per falling edge.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                check("valA", valA, it.a);
                check("valB", valB, it.b);
                for (int i = 0; i < 15; i++)
                    check($sformatf("reg_f%0d", i), dut_regs[i], it.regs[i]);
            end
        end
    end

    initial begin
        int waited;
        reset_model();
        // Reset state, then icode 1 reads nothing.
        drive(4'h1, 4'h2, 4'h3, 1'b1, 64'h11, 64'h22);
        // irmovq 5 -> r2, then opq r2,r3 reads 5 and 0.
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h5, 64'h0);
        drive(4'h6, 4'h2, 4'h3, 1'b0, 64'h0, 64'h0);
        // cmov with cnd=0 leaves r1, cnd=1 writes it.
        drive(4'h2, 4'h2, 4'h1, 1'b0, 64'h9, 64'h0);
        drive(4'h2, 4'h2, 4'h1, 1'b1, 64'h9, 64'h0);
        // %rsp = 0x28, popq %rsp: M wins over E.
        drive(4'h3, 4'hF, 4'h4, 1'b0, 64'h28, 64'h0);
        drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h30, 64'h20);
        // pushq r2: valA=5, valB=0x20, %rsp -> 0x18.
        drive(4'hA, 4'h2, 4'hF, 1'b0, 64'h18, 64'h0);
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        // Mid-cycle reset.
        reset_pulse();
        drive(4'h1, 4'h4, 4'h4, 1'b0, 64'h0, 64'h0);
        // Randomised instructions with occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset_pulse();
            end else begin
                drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      {$urandom, $urandom}, {$urandom, $urandom});
            end
        end
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all register-file writes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 icode  input  4  instruction code of the current instruction.
REQ-005 rA  input  4  register specifier A; 4'hF = none.
REQ-006 rB  input  4  register specifier B; 4'hF = none.
REQ-007 cnd  input  1  condition flag from execute; qualifies cmovXX writeback.
REQ-008 valM  input  64 signed  memory-stage result for writeback.
REQ-009 valE  input  64 signed  execute-stage result for writeback.
REQ-010 valA  output  64 signed  decoded operand A.
REQ-011 valB  output  64 signed  decoded operand B.
REQ-012 reg_f0 .. reg_f14  output  64 signed each  current contents of registers 0..14 (register 4 = %rsp).

Function
REQ-013 The block SHALL hold a 15 x 64-bit register file; index 4'hF is never stored.
REQ-014 srcA SHALL be rA for icode 2, 4, 6, A; 4 (%rsp) for icode 9, B; otherwise none.
REQ-015 srcB SHALL be rB for icode 4, 5, 6; 4 (%rsp) for icode 8, 9, A, B; otherwise none.
REQ-016 valA/valB SHALL be combinational reads of reg[srcA]/reg[srcB]; SHALL be 0 when the source is none or 4'hF.
REQ-017 dstE SHALL be rB for icode 2 only when cnd=1, rB for icode 3 and 6, 4 for icode 8, 9, A, B; otherwise none.
REQ-018 dstM SHALL be rA for icode 5 and B; otherwise none.
REQ-019 On each rising clk edge (reset low): reg[dstE] <= valE, reg[dstM] <= valM; a destination of none or 4'hF SHALL write nothing.
REQ-020 When dstE == dstM (popq %rsp), valM SHALL win.
REQ-021 icode 0, 1 and icode > 4'hB SHALL produce no write and valA=valB=0.
REQ-022 Reads in the same cycle as a write SHALL return the pre-edge value (no bypass).
REQ-023 reg_fN outputs SHALL mirror register N continuously.

Reset
REQ-024 reset high SHALL immediately clear all 15 registers to 0 (see REQ-026), independent of clk.
REQ-025 While reset is high, writes SHALL be suppressed; normal operation resumes on the first rising edge after deassertion.

Configuration
REQ-026 Macro DECODE_STACK_INIT_EN: when defined, reset loads register 4 (%rsp) with 64'h0000_0000_0000_0100. When undefined, register 4 resets to 0 like all other registers.

Structure
REQ-027 A shared package SHALL hold icode constants (HALT=0 .. POPQ=B), register indices RSP=4 and RNONE=F, and the 64-bit word type.
REQ-028 The register file SHALL be one sub-module, decode_regfile: 2 read ports, 2 write ports, M-priority.

Verification
REQ-029 Assert reset -> all reg_fN = 0 (reg_f4 = 0x100 with DECODE_STACK_INIT_EN); icode=1 -> valA=valB=0.
REQ-030 icode=3, rB=2, valE=5, rising edge -> reg_f2=5; then icode=6, rA=2, rB=3 -> valA=5, valB=0.
REQ-031 icode=2, rA=2, rB=1, cnd=0, valE=9, rising edge -> reg_f1 unchanged; repeat with cnd=1 -> reg_f1=9.
REQ-032 reg_f4=0x28: icode=B, rA=4, valE=0x30, valM=0x20, rising edge -> reg_f4=0x20 (M wins).
REQ-033 icode=A, rA=2 with reg_f2=5, reg_f4=0x20 -> valA=5, valB=0x20; rising edge with valE=0x18 -> reg_f4=0x18.
REQ-034 Reset asserted mid-cycle between edges -> registers clear at once, without waiting for a clk edge.
